// File: rtl/array_alu_wr_feeder.sv
// array_alu_wr_feeder: turns a valid/ready word stream into single-beat AXI4
// writes to consecutive, wrapping array addresses. Outstanding writes are
// bounded, and completed and failed B responses are counted.
module array_alu_wr_feeder #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                NUM_WORDS  = 16,
  parameter int                MAX_OUTST  = 4,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              clr_idx,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  output logic              busy,
  output logic [15:0]       wr_cnt,
  output logic [7:0]        err_cnt
);

  localparam int STRIDE = DATA_W / 8;
  localparam int IW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int OW     = $clog2(MAX_OUTST + 1);
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_WORDS - 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_SLOT = 2'd2;

  // Input buffer. The pointers wrap naturally because the depth is a power of 2.
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wrPtr_q, rdPtr_q;
  logic [CW-1:0]     fifoCnt_q;
  logic              fifoFull, fifoEmpty, push, pop;

  logic [1:0]        state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic [DATA_W-1:0] beat_q, beat_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [15:0]       wrCnt_q;
  logic [7:0]        errCnt_q;

  logic awHs, wHs, bHs, awDone, wDone;

  assign fifoFull  = (fifoCnt_q == FIFO_FULL);
  assign fifoEmpty = (fifoCnt_q == '0);
  assign s_ready   = ~reset & ~fifoFull;
  assign bready    = ~reset;
  assign push      = s_valid & s_ready;

  assign awHs   = awvalid_q & awready;
  assign wHs    = wvalid_q & wready;
  assign bHs    = bvalid & bready;
  // A channel counts as done once its valid has dropped or is handshaking now.
  assign awDone = ~awvalid_q | awHs;
  assign wDone  = ~wvalid_q | wHs;

  assign busy    = ~fifoEmpty | (state_q != S_IDLE) | (outst_q != '0);
  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign wdata   = beat_q;
  assign awaddr  = BASE_ADDR + (ADDR_W'(idx_q) * ADDR_W'(STRIDE));
  assign wr_cnt  = wrCnt_q;
  assign err_cnt = errCnt_q;

  // Buffer storage is written on every accepted word and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= s_data;
  end

  // Buffer pointers and occupancy; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fifoCnt_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      fifoCnt_q <= fifoCnt_q + CW'(push) - CW'(pop);
    end
  end

  // Beat FSM: pop a word into the beat register, drive AW and W, advance the index.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifoEmpty) begin
          if (outst_q < OUTST_MAX) begin
            pop       = 1'b1;
            beat_d    = mem_q[rdPtr_q];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_ISSUE;
          end else begin
            state_d = S_WAIT_SLOT;
          end
        end
      end
      S_WAIT_SLOT: begin
        if (bHs) state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (awHs) awvalid_d = 1'b0;
        if (wHs)  wvalid_d  = 1'b0;
        if (awDone && wDone) begin
          state_d = S_IDLE;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clr_idx && !busy) idx_d = '0;
  end

  // Outstanding count: AW handshakes add, B handshakes subtract, a stray B is ignored.
  always_comb begin
    outst_d = outst_q;
    if (awHs && !(bHs && outst_q != '0)) begin
      outst_d = outst_q + OW'(1);
    end else if (!awHs && bHs && outst_q != '0) begin
      outst_d = outst_q - OW'(1);
    end
  end

  // FSM, beat and index registers; reset drops any beat in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      beat_q    <= '0;
      idx_q     <= '0;
      outst_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      outst_q   <= outst_d;
    end
  end

  // Response counters: every B counts, error responses saturate at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrCnt_q  <= '0;
      errCnt_q <= '0;
    end else if (bHs) begin
      wrCnt_q <= wrCnt_q + 16'd1;
      if (bresp != 2'b00 && errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
    end
  end

endmodule

// File: doc/array_alu_wr_feeder.md
Name: array_alu_wr_feeder

Overview:
- Upstream stage of array_alu: converts a valid/ready word stream into single-beat AXI4 write transactions (AW/W/B) on array_alu's write port.
- Writes each word to a consecutive array address, wrapping over a fixed array window.
- Bounds outstanding writes and counts completed and failed responses for the bench/scoreboard.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width; byte stride = DATA_W/8.
- BASE_ADDR, 0, address of array element 0.
- NUM_WORDS, 16, array length; index wraps NUM_WORDS-1 -> 0.
- MAX_OUTST, 4, maximum AW handshakes without a matching B.
- FIFO_DEPTH, 2, input buffer entries (power of 2).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid&&s_ready.
- s_data  in  DATA_W  input word.
- clr_idx  in  1  reset write index to 0; honoured only when busy==0.
- awvalid  out  1  AXI write address valid.
- awready  in  1  AXI write address ready.
- awaddr  out  ADDR_W  AXI write address.
- wvalid  out  1  AXI write data valid.
- wready  in  1  AXI write data ready.
- wdata  out  DATA_W  AXI write data.
- bvalid  in  1  AXI write response valid.
- bresp  in  2  AXI write response code.
- bready  out  1  AXI write response ready.
- busy  out  1  FIFO non-empty, beat in flight, or outstanding != 0.
- wr_cnt  out  16  B responses received (wraps).
- err_cnt  out  8  B responses with bresp != 0 (saturates at 255).

Behaviour:
- Reset (reset==1 at posedge): awvalid=0, wvalid=0, bready=0, s_ready=0, busy=0, wr_cnt=0, err_cnt=0, idx=0, outstanding=0, FIFO emptied, FSM=IDLE. The first cycle after reset is released: bready=1, s_ready=1.
- A reset asserted mid-transaction drops the in-flight beat and outstanding count without waiting for B. Downstream is reset together.
- s_ready = FIFO not full. Input acceptance is independent of AXI state.
- FSM IDLE: if FIFO non-empty and outstanding<MAX_OUTST, pop the head into the beat register. Next cycle enter ISSUE with awvalid=1, wvalid=1, awaddr=BASE_ADDR+idx*(DATA_W/8), wdata=head. Minimum latency from s_valid&&s_ready to awvalid is 2 cycles.
- If FIFO non-empty but outstanding==MAX_OUTST: enter WAIT_SLOT and leave on the first B handshake.
- FSM ISSUE: AW and W complete independently, each tracked by its own done flag.
  - awvalid drops the cycle after awvalid&&awready; wvalid drops the cycle after wvalid&&wready.
  - awaddr and wdata stay stable while the corresponding valid is high. A valid is never withdrawn before its handshake.
  - When both are done: idx advances (idx==NUM_WORDS-1 -> 0) and the FSM returns to IDLE. Back-to-back beats leave one idle cycle between them.
- Outstanding counter: +1 on AW handshake, -1 on B handshake; a simultaneous AW and B handshake leaves it unchanged. Never exceeds MAX_OUTST and never underflows.
- A B handshake with outstanding==0 is a protocol error: it is ignored for the counter but still counted in wr_cnt.
- bready is held 1 outside reset. Each bvalid&&bready cycle increments wr_cnt. If bresp!=0, err_cnt also increments, saturating at 255.
- clr_idx while busy==1 is ignored. When busy==0, idx=0 on the next cycle. clr_idx in the same cycle as an s_valid acceptance still clears, since the word is only popped later.
- The beat is launched on W and AW together; W is never issued before its AW beat is formed.

Test Plan:
- Single write, awready/wready tied 1, bvalid one cycle after AW, bresp=0: push 0xDEADBEEF -> awaddr=BASE_ADDR, wdata=0xDEADBEEF, awvalid 2 cycles after accept, wr_cnt=1, busy=0 after B.
- Address wrap, NUM_WORDS=16: push 18 words 0..17 -> awaddr sequence 0x00,0x04,...,0x3C,0x00,0x04; data order preserved.
- Skewed handshake: wready asserted 3 cycles before awready -> wvalid drops after its handshake, awvalid/awaddr stay stable until awready, exactly one beat issued.
- Outstanding limit, MAX_OUTST=4, bvalid held 0: push 6 words -> exactly 4 AW handshakes, FSM in WAIT_SLOT, s_ready=0 once FIFO full. Release B responses -> remaining 2 beats issue, wr_cnt=6.
- Errors: 3 writes with bresp=2'b10,2'b00,2'b11 -> err_cnt=2, wr_cnt=3. 300 erroring writes -> err_cnt=255.
- Reset mid-operation after 2 of 5 words written: assert reset 1 cycle -> awvalid=wvalid=0, wr_cnt=0, idx=0. A new push goes to BASE_ADDR. clr_idx while busy=1 has no effect.
